// File: rtl/sm4_round_ctrl.sv
// sm4_round_ctrl: iterative SM4 round sequencer, one round per clock,
// sharing a single T (S-box + L) instance across all rounds.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_decrypt/
//   in_data block input; rk_idx/rk_data round-key fetch (same cycle);
//   out_valid/out_ready/out_data result; busy (high while rounds run).
// Option: define SM4_ROUND_CTRL_ABORT_EN to add an abort input that
//   cancels the block in flight.
module sm4_round_ctrl #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         reset,
`ifdef SM4_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [127:0] in_data,
    output logic [4:0]   rk_idx,
    input  logic [31:0]  rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    // Byte i of the S-box sits at bits [2047-8i -: 8].
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // (255 - a) * 8 == {~a, 3'b000} for an 8-bit index.
    function automatic logic [31:0] t_fn(input logic [31:0] a);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            b[8*i +: 8] = SBOX[{~a[8*i +: 8], 3'b000} +: 8];
        end
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic        dec;
    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] x3;
    logic [31:0] new_x;
    logic        abort_hit;

`ifdef SM4_ROUND_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign new_x    = x0 ^ t_fn(x1 ^ x2 ^ x3 ^ rk_data);
    assign out_data = {x3, x2, x1, x0};
    assign rk_idx   = (state == RUN) ? (dec ? LAST - cnt : cnt) : 5'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort_hit) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            cnt <= '0;
            dec <= 1'b0;
            x0  <= '0;
            x1  <= '0;
            x2  <= '0;
            x3  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0  <= in_data[127:96];
                        x1  <= in_data[95:64];
                        x2  <= in_data[63:32];
                        x3  <= in_data[31:0];
                        dec <= in_decrypt;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    x0  <= x1;
                    x1  <= x2;
                    x2  <= x3;
                    x3  <= new_x;
                    // Clear on the last round so cnt never wraps in RUN.
                    cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// tb_sm4_round_ctrl: randomized + directed bench for sm4_round_ctrl with a
// reference SM4 model, key schedule and scoreboard.
module tb_sm4_round_ctrl;

    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic         clk = 1'b0;
    logic         reset;
`ifdef SM4_ROUND_CTRL_ABORT_EN
    logic         abort;
`endif
    logic         in_valid;
    logic         in_ready;
    logic         in_decrypt;
    logic [127:0] in_data;
    logic [4:0]   rk_idx;
    logic [31:0]  rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [31:0]  rk_mem [32];

    always #5 clk = ~clk;

    assign rk_data = rk_mem[rk_idx];

    sm4_round_ctrl dut (
`ifdef SM4_ROUND_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_data    (in_data),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    logic [2047:0] sb_tab = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [7:0] sb(input logic [7:0] a);
        int p;
        p = 2047 - 8 * int'(a);
        return sb_tab[p -: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] w);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = sb(w[8*j +: 8]);
        return b;
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] w);
        logic [31:0] b;
        b = tau(w);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] w);
        logic [31:0] b;
        b = tau(w);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    task automatic expand_key(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] fk [4];
        logic [31:0] ck;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
            k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk_mem[i] = k[i+4];
        end
    endtask

    function automatic logic [127:0] sm4_ref(input logic [127:0] blk,
                                             input logic dec);
        logic [31:0] x [36];
        logic [31:0] rk;
        for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            rk = dec ? rk_mem[31-i] : rk_mem[i];
            x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Scoreboard and monitor
    logic [127:0] exp_q [$];
    int   cyc       = 0;
    int   acc_cyc   = 0;
    int   last_rise = -100;
    int   run_k     = 0;
    logic run_dec   = 1'b0;
    logic ov_prev   = 1'b0;
    logic flush;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef SM4_ROUND_CTRL_ABORT_EN
    assign flush = reset || (abort && !in_ready);
`else
    assign flush = reset;
`endif

    always @(negedge clk) begin
        if (flush) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (busy) begin
                chk("rk_idx_run", 128'(rk_idx),
                    128'(run_dec ? 31 - run_k : run_k));
                run_k++;
            end else begin
                chk("rk_idx_idle", 128'(rk_idx), 128'd0);
            end
            if (out_valid && !ov_prev) begin
                last_rise = cyc;
                chk("latency", 128'(cyc - acc_cyc), 128'd32);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_out");
                else chk("result", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(sm4_ref(in_data, in_decrypt));
                acc_cyc = cyc + 1;
                run_k   = 0;
                run_dec = in_decrypt;
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [127:0] d, input logic dec);
        int n = 0;
        in_data    = d;
        in_decrypt = dec;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [127:0] d);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("wait_out");
        d = out_data;
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        @(negedge clk);
        while (!(busy && rk_idx == 5'(r)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("wait_round");
    endtask

    initial begin
        logic [127:0] r;
        logic [127:0] r2;
        int acc2;
        int sent;
        int n;
        logic acc;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b1;
`ifdef SM4_ROUND_CTRL_ABORT_EN
        abort      = 1'b0;
`endif
        expand_key(KEY);
        chk("rk0", 128'(rk_mem[0]), 128'h f12186f9);
        chk("rk31", 128'(rk_mem[31]), 128'h9124a012);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        send(PT, 1'b0);
        wait_out(r);
        chk("enc_vec", r, CT);
        @(posedge clk);
        #1;

        send(CT, 1'b1);
        wait_out(r);
        chk("dec_vec", r, PT);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(PT, 1'b0);
        wait_out(r);
        @(posedge clk);
        #1;
        in_data    = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data", out_data, r);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_post_ready", 128'(in_ready), 128'd1);
        chk("bp_post_busy", 128'(busy), 128'd0);
        chk("bp_post_ov", 128'(out_valid), 128'd0);
        @(negedge clk);
        chk("bp_accept", 128'(busy), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(r2);
        @(posedge clk);
        #1;

        send(PT, 1'b0);
        wait_round(14);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_ov", 128'(out_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        send(PT, 1'b0);
        wait_out(r);
        chk("enc_after_rst", r, CT);
        @(posedge clk);
        #1;

        in_data    = PT;
        in_decrypt = 1'b0;
        in_valid   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 in_data = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("b2b_accept");
        acc2 = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_gap", 128'(acc2 - last_rise), 128'd2);
        wait_out(r);
        @(posedge clk);
        #1;

`ifdef SM4_ROUND_CTRL_ABORT_EN
        send(PT, 1'b0);
        wait_round(19);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_ov", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        send(PT, 1'b0);
        wait_out(r);
        chk("enc_after_abort", r, CT);
        @(posedge clk);
        #1;
`endif

        sent = 0;
        n    = 0;
        while ((sent < 24 || exp_q.size() != 0 || busy || out_valid)
               && n < 5000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            if (!in_valid && sent < 24 && $urandom_range(0, 1) == 1) begin
                in_data    = {$urandom, $urandom, $urandom, $urandom};
                in_decrypt = 1'($urandom_range(0, 1));
                in_valid   = 1'b1;
            end
            n++;
        end
        if (n >= 5000) fail_now("random_phase");
        chk("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sm4_round_ctrl.md
Name: sm4_round_ctrl

Overview:
- Iterative SM4 cipher-round sequencer.
- Time-shares one T_for_encdec instance (S-box plus linear transform L) across all 32 rounds, one round per clock.
- Accepts a 128-bit block through a valid/ready handshake and fetches one 32-bit round key per cycle from an external key store (index out, key in same cycle).
- Returns the reverse-ordered result block through a valid/ready handshake. Supports encrypt and decrypt.

Parameters:
- ROUNDS, 32, number of rounds executed per block. Legal values: 1..32. Key index width is fixed at 5 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input block offered
- in_ready  output  1  controller can accept a block
- in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with in_data
- in_data  input  128  block {X0,X1,X2,X3}, X0 in bits [127:96]
- rk_idx  output  5  round-key index requested this cycle
- rk_data  input  32  round key for rk_idx, combinational from key store
- out_valid  output  1  result block available
- out_ready  input  1  consumer accepts result
- out_data  output  128  result {X35,X34,X33,X32}
- busy  output  1  high in RUN state

Behaviour:
- Reset:
  - state = IDLE, round counter cnt = 0, X registers cleared.
  - in_ready = 1, out_valid = 0, busy = 0, rk_idx = 0, out_data = 0.
- Reset is synchronous. Asserting reset mid-RUN or in DONE discards the block; the controller is back in IDLE on the next cycle.
- States:
  - IDLE: in_ready = 1.
    - On in_valid & in_ready: latch X0..X3 and the decrypt flag, set cnt = 0, go to RUN.
  - RUN: in_ready = 0, busy = 1.
    - rk_idx = cnt when encrypting; rk_idx = ROUNDS-1-cnt when decrypting.
    - Each edge: newX = X0 ^ T(X1^X2^X3^rk_data). Shift {X0,X1,X2,X3} <= {X1,X2,X3,newX}. cnt increments.
    - When cnt == ROUNDS-1 at the edge, go to DONE.
  - DONE: out_valid = 1. out_data = {X3,X2,X1,X0}, i.e. reverse word order. out_data is a registered output, stable while out_valid is high.
    - On out_ready, go to IDLE.
- rk_idx is held at 0 outside RUN.
- Latency:
  - Input handshake at edge N; out_valid rises after edge N+ROUNDS (32 cycles for the default).
  - Minimum block period: ROUNDS+2 cycles (accept, rounds, output handshake, idle cycle).
- Back-pressure: out_valid and out_data are held indefinitely while out_ready = 0. No new input is accepted until the output handshake completes.
- in_valid while not in IDLE is ignored and not queued. in_data and in_decrypt are read only at the accepting edge.
- out_ready while out_valid = 0 has no effect.
- cnt is a 5-bit counter and never wraps inside RUN.
- All 32-bit XOR arithmetic is modulo-free bitwise; there is no carry path.

Optional Feature:
- Macro: SM4_ROUND_CTRL_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort = 1 in RUN or DONE: next state IDLE, out_valid = 0, busy = 0. The block is discarded, X registers are cleared and cnt = 0.
  - abort in IDLE is ignored.
  - If abort and in_valid are both high in IDLE, the block is accepted.
  - reset has priority over abort.
- Undefined: no abort port. The only way to cancel a block is reset.

Test Plan:
- Encrypt vector. Key store loaded with the expanded keys of 0123456789abcdeffedcba9876543210 (rk0 = f12186f9, rk31 = 9124a012). in_data = 0123456789abcdeffedcba9876543210, in_decrypt = 0. Required: out_data = 681edf34d206965e86b3e94f536e4246, out_valid exactly 32 cycles after the accept edge. During RUN, rk_idx sequences 0..31.
- Decrypt vector. Same key store, in_data = 681edf34d206965e86b3e94f536e4246, in_decrypt = 1. Required: out_data = 0123456789abcdeffedcba9876543210, rk_idx sequences 31..0.
- Back-pressure. out_ready = 0 for 10 cycles after out_valid rises. Required: out_data stable and in_ready = 0 throughout; a new in_valid is not accepted until the cycle after the out_ready handshake.
- Reset mid-run. Assert reset at round 15. Required: next cycle in_ready = 1, out_valid = 0, busy = 0. A fresh encrypt-vector run then produces the correct ciphertext.
- Back-to-back. Two encrypt blocks with in_valid held high and out_ready = 1. Required: second accept occurs 2 cycles after the first out_valid edge, and both results are correct.
- With SM4_ROUND_CTRL_ABORT_EN defined: abort at round 20. Required: IDLE next cycle, no out_valid pulse, and the following block completes correctly.
